// File: rtl/led_pulse_driver_pkg.sv
// -----------------------------------------------------------------------------
// led_pulse_driver_pkg
//   Shared definitions for the timed-output blocks (LED/buzzer driver and the
//   button conditioning chain).
//   - STATE_*_ENC : state encodings for the IDLE / ON / OFF sequencing FSM
//   - state_t     : enum built on those encodings
//   - timer_width : width of a down-counter able to hold the longer of two
//                   periods
// -----------------------------------------------------------------------------
package led_pulse_driver_pkg;

    localparam logic [1:0] STATE_IDLE_ENC = 2'd0;
    localparam logic [1:0] STATE_ON_ENC   = 2'd1;
    localparam logic [1:0] STATE_OFF_ENC  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = STATE_IDLE_ENC,
        S_ON   = STATE_ON_ENC,
        S_OFF  = STATE_OFF_ENC
    } state_t;

    // Bits needed to load max(on_time, off_time) into a down-counter.
    function automatic int timer_width(input int on_time, input int off_time);
        int longest;
        longest = (on_time > off_time) ? on_time : off_time;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/led_pulse_driver_cycle_timer.sv
// -----------------------------------------------------------------------------
// cycle_timer
//   Loadable down-counter that marks the last cycle of a loaded period.
//   Loading value N makes expired high in the Nth cycle after the load edge.
//   The count stops at zero, so it never wraps.
//
//   clk        in   system clock
//   reset      in   synchronous active-high reset (count cleared to 0)
//   load       in   load load_value on this edge
//   load_value in   period length in cycles (>= 1)
//   expired    out  high during the final cycle of the loaded period
// -----------------------------------------------------------------------------
module cycle_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired
);

    logic [WIDTH-1:0] r_count;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values; the reset branch clears the count explicitly.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign expired = (r_count == WIDTH'(1));

endmodule

// File: rtl/led_pulse_driver.sv
// -----------------------------------------------------------------------------
// led_pulse_driver
//   Emits a requested number of pulses on led_out, each ON_TIME cycles high
//   followed by OFF_TIME cycles low (the last pulse included), so consecutive
//   sequences are always separated by at least OFF_TIME low cycles.
//
//   clk     in   system clock
//   reset   in   synchronous active-high reset, dominates all inputs
//   start   in   request strobe; accepted only in IDLE with count != 0
//   count   in   pulse count, sampled with start
//   stop    in   abort; returns to IDLE without done, wins over start
//   led_out out  registered LED/buzzer enable
//   busy    out  registered, high while a sequence is running
//   done    out  registered one-cycle pulse on normal completion
// -----------------------------------------------------------------------------
module led_pulse_driver
    import led_pulse_driver_pkg::*;
#(
    parameter int ON_TIME  = 25000000,
    parameter int OFF_TIME = 25000000,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             stop,
    output logic             led_out,
    output logic             busy,
    output logic             done
);

    localparam int TIMER_W = timer_width(ON_TIME, OFF_TIME);
    localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_TIME);
    localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(OFF_TIME);

    state_t             r_state;
    logic [CNT_W-1:0]   r_remaining;
    logic               r_led;
    logic               r_busy;
    logic               r_done;

    state_t             w_state_next;
    logic [CNT_W-1:0]   w_remaining_next;
    logic               w_done_next;
    logic               w_load;
    logic [TIMER_W-1:0] w_load_value;
    logic               w_expired;

    cycle_timer #(
        .WIDTH(TIMER_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (w_load),
        .load_value(w_load_value),
        .expired   (w_expired)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_next     = r_state;
        w_remaining_next = r_remaining;
        w_done_next      = 1'b0;
        w_load           = 1'b0;
        w_load_value     = ON_LOAD;

        unique case (r_state)
            S_IDLE: begin
                if (start && !stop && (count != '0)) begin
                    w_state_next     = S_ON;
                    w_remaining_next = count;
                    w_load           = 1'b1;
                    w_load_value     = ON_LOAD;
                end
            end
            S_ON: begin
                if (stop) begin
                    w_state_next     = S_IDLE;
                    w_remaining_next = '0;
                end else if (w_expired) begin
                    w_state_next = S_OFF;
                    w_load       = 1'b1;
                    w_load_value = OFF_LOAD;
                end
            end
            S_OFF: begin
                if (stop) begin
                    w_state_next     = S_IDLE;
                    w_remaining_next = '0;
                end else if (w_expired) begin
                    // A pulse finishes only after its trailing OFF period.
                    w_remaining_next = r_remaining - CNT_W'(1);
                    if (r_remaining == CNT_W'(1)) begin
                        w_state_next = S_IDLE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_state_next = S_ON;
                        w_load       = 1'b1;
                        w_load_value = ON_LOAD;
                    end
                end
            end
            default: begin
                w_state_next     = S_IDLE;
                w_remaining_next = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state
    // register instead of lagging it by a cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_led       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_remaining <= w_remaining_next;
            r_led       <= (w_state_next == S_ON);
            r_busy      <= (w_state_next != S_IDLE);
            r_done      <= w_done_next;
        end
    end

    assign led_out = r_led;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_led_pulse_driver.sv
// -----------------------------------------------------------------------------
// tb_led_pulse_driver
//   Directed bench for led_pulse_driver with ON_TIME=4, OFF_TIME=3, CNT_W=4.
//   Cycle 0 is the cycle in which start is driven high; outputs for cycle c
//   are sampled 1 ns after the rising edge that ends cycle c-1.
// -----------------------------------------------------------------------------
module tb_led_pulse_driver;

    localparam int ON_T  = 4;
    localparam int OFF_T = 3;
    localparam int PER   = ON_T + OFF_T;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] count;
    logic       stop;
    logic       led_out;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    led_pulse_driver #(
        .ON_TIME (ON_T),
        .OFF_TIME(OFF_T),
        .CNT_W   (4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .count  (count),
        .stop   (stop),
        .led_out(led_out),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset held with a pending request: nothing may start.
    task automatic test_reset();
        logic [2:0] exp;
        reset = 1'b1; start = 1'b1; count = 4'd2; stop = 1'b0;
        exp = 3'b000;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({led_out, busy, done} !== exp) begin
                bad++;
                $display("FAIL reset_hold i=%0d got led/busy/done=%b expected %b", i, {led_out, busy, done}, exp);
            end
        end
        reset = 1'b0; start = 1'b0; count = 4'd0;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if ({led_out, busy, done} !== exp) begin
                bad++;
                $display("FAIL reset_release i=%0d got led/busy/done=%b expected %b", i, {led_out, busy, done}, exp);
            end
        end
    endtask

    // count=1: led 1-4, busy 1-7, done at 8.
    task automatic test_single();
        logic [2:0] exp;
        start = 1'b1; count = 4'd1;
        for (int c = 1; c <= 9; c++) begin
            step();
            start = 1'b0;
            exp = {(c <= 4), (c <= 7), (c == 8)};
            total++;
            if ({led_out, busy, done} !== exp) begin
                bad++;
                $display("FAIL single c=%0d got led/busy/done=%b expected %b", c, {led_out, busy, done}, exp);
            end
        end
    endtask

    // count=3 then a start in the done cycle (count=1) runs back to back.
    task automatic test_back_to_back();
        logic [2:0] exp;
        start = 1'b1; count = 4'd3;
        for (int c = 1; c <= 31; c++) begin
            step();
            start = 1'b0;
            if (c <= 3 * PER)
                exp = {(((c - 1) % PER) < ON_T), 1'b1, 1'b0};
            else if (c == 22 || c == 30)
                exp = 3'b001;
            else if (c >= 23 && c <= 29)
                exp = {((c - 23) < ON_T), 1'b1, 1'b0};
            else
                exp = 3'b000;
            total++;
            if ({led_out, busy, done} !== exp) begin
                bad++;
                $display("FAIL back_to_back c=%0d got led/busy/done=%b expected %b", c, {led_out, busy, done}, exp);
            end
            if (c == 22) begin
                start = 1'b1;
                count = 4'd1;
            end
        end
    endtask

    // count=0 is ignored; a start while busy does not change the count.
    task automatic test_zero_and_ignored();
        logic [2:0] exp;
        start = 1'b1; count = 4'd0;
        for (int c = 1; c <= 3; c++) begin
            step();
            start = 1'b0;
            exp = 3'b000;
            total++;
            if ({led_out, busy, done} !== exp) begin
                bad++;
                $display("FAIL zero_count c=%0d got led/busy/done=%b expected %b", c, {led_out, busy, done}, exp);
            end
        end
        start = 1'b1; count = 4'd2;
        for (int c = 1; c <= 18; c++) begin
            step();
            start = 1'b0;
            if (c <= 2 * PER)
                exp = {(((c - 1) % PER) < ON_T), 1'b1, 1'b0};
            else if (c == 15)
                exp = 3'b001;
            else
                exp = 3'b000;
            total++;
            if ({led_out, busy, done} !== exp) begin
                bad++;
                $display("FAIL busy_start c=%0d got led/busy/done=%b expected %b", c, {led_out, busy, done}, exp);
            end
            if (c == 3) begin
                start = 1'b1;
                count = 4'd5;
            end
        end
    endtask

    // stop during OFF aborts silently; stop with start in IDLE wins.
    task automatic test_stop();
        logic [2:0] exp;
        start = 1'b1; count = 4'd2;
        for (int c = 1; c <= 20; c++) begin
            step();
            start = 1'b0;
            stop  = 1'b0;
            if (c <= 6)
                exp = {(((c - 1) % PER) < ON_T), 1'b1, 1'b0};
            else
                exp = 3'b000;
            total++;
            if ({led_out, busy, done} !== exp) begin
                bad++;
                $display("FAIL stop_abort c=%0d got led/busy/done=%b expected %b", c, {led_out, busy, done}, exp);
            end
            if (c == 6) stop = 1'b1;
        end
        start = 1'b1; stop = 1'b1; count = 4'd3;
        for (int c = 1; c <= 5; c++) begin
            step();
            start = 1'b0;
            stop  = 1'b0;
            exp = 3'b000;
            total++;
            if ({led_out, busy, done} !== exp) begin
                bad++;
                $display("FAIL stop_with_start c=%0d got led/busy/done=%b expected %b", c, {led_out, busy, done}, exp);
            end
        end
    endtask

    // Reset mid-sequence clears everything; a fresh start then works normally.
    task automatic test_reset_mid();
        logic [2:0] exp;
        start = 1'b1; count = 4'd2;
        for (int c = 1; c <= 18; c++) begin
            step();
            start = 1'b0;
            reset = 1'b0;
            exp = (c <= 2) ? 3'b110 : 3'b000;
            total++;
            if ({led_out, busy, done} !== exp) begin
                bad++;
                $display("FAIL reset_mid c=%0d got led/busy/done=%b expected %b", c, {led_out, busy, done}, exp);
            end
            if (c == 2) reset = 1'b1;
        end
        start = 1'b1; count = 4'd1;
        for (int c = 1; c <= 9; c++) begin
            step();
            start = 1'b0;
            exp = {(c <= 4), (c <= 7), (c == 8)};
            total++;
            if ({led_out, busy, done} !== exp) begin
                bad++;
                $display("FAIL after_reset c=%0d got led/busy/done=%b expected %b", c, {led_out, busy, done}, exp);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        count = 4'd0;
        stop  = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_zero_and_ignored();
        test_stop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
